// File: rtl/truth_table_scanner.sv
// Sweep-and-capture self-check for an N-input combinational function: drives every
// input vector on x, samples s after a settle delay, and builds a minterm mask and count.
module truth_table_scanner #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [N-1:0]      x,
    input  logic              s,
    input  logic [2**N-1:0]   expected,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   mask,
    output logic [N:0]        ones,
    output logic              match
);

    localparam int W  = 2**N;
    localparam int OW = N + 1;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [N-1:0]  X_LAST   = '1;

    typedef enum logic [1:0] {IDLE, HOLD, FINISH} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            sample;
    logic [W-1:0]    mask_upd;

    assign sample = (state == HOLD) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = HOLD;
            HOLD:    if (sample && (x == X_LAST)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == HOLD);
        done = (state == FINISH);
    end

    // Mask as it will look after this edge; the last vector's sample must be
    // included when match is registered on the FINISH entry edge.
    always_comb begin
        mask_upd    = mask;
        mask_upd[x] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            mask  <= '0;
            ones  <= '0;
            match <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x     <= '0;
                        mask  <= '0;
                        ones  <= '0;
                        match <= 1'b0;
                        cnt   <= SETTLE_C;
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        mask <= mask_upd;
                        ones <= ones + OW'(s);
                        if (x == X_LAST) begin
                            match <= (mask_upd == expected);
                        end else begin
                            x   <= x + N'(1);
                            cnt <= SETTLE_C;
                        end
                    end
                end
                FINISH: x <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: stimulus pushes expected scan results,
// per-instance monitors pop and compare on every done pulse.
module tb_truth_table_scanner;

    typedef struct {
        logic [15:0] mask;
        logic [4:0]  ones;
        logic        match;
        int          done_cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_aux;
    logic [1:0]  s_sel;
    logic [15:0] expected;
    logic [15:0] expected_aux;

    logic [3:0]  x,     x0,     x3;
    logic        s,     s0,     s3;
    logic        busy,  busy0,  busy3;
    logic        done,  done0,  done3;
    logic [15:0] mask,  mask0,  mask3;
    logic [4:0]  ones,  ones0,  ones3;
    logic        match, match0, match3;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];
    exp_t sb0[$];
    exp_t sb3[$];

    // SoP with minterms {4,8,9,12,13,14}: b~c~d + a~c + ab~d
    function automatic logic sop(input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        return (b & ~c & ~d) | (a & ~c) | (a & b & ~d);
    endfunction

    assign s  = (s_sel == 2'd0) ? sop(x) : (s_sel == 2'd1);
    assign s0 = sop(x0);
    assign s3 = sop(x3);

    truth_table_scanner #(.N(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .s(s), .expected(expected),
        .busy(busy), .done(done), .mask(mask), .ones(ones), .match(match));

    truth_table_scanner #(.N(4), .SETTLE(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .x(x0), .s(s0), .expected(expected_aux),
        .busy(busy0), .done(done0), .mask(mask0), .ones(ones0), .match(match0));

    truth_table_scanner #(.N(4), .SETTLE(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_aux), .x(x3), .s(s3), .expected(expected_aux),
        .busy(busy3), .done(done3), .mask(mask3), .ones(ones3), .match(match3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_item(input string tag, input exp_t e, input logic [15:0] m,
                              input logic [4:0] o, input logic mt);
        check_output({tag, "_mask"}, m, e.mask);
        check_output({tag, "_ones"}, o, e.ones);
        check_output({tag, "_match"}, mt, e.match);
        check_output({tag, "_done_cycle"}, cyc, e.done_cyc);
    endtask

    task automatic unexpected_done(input string tag);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s_unexpected_done: got done=1 required done=0 (cycle %0d)", tag, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) unexpected_done("main");
            else check_item("main", sb.pop_front(), mask, ones, match);
        end
    end

    always @(negedge clk) begin
        if (rst_n && done0) begin
            if (sb0.size() == 0) unexpected_done("settle0");
            else check_item("settle0", sb0.pop_front(), mask0, ones0, match0);
        end
    end

    always @(negedge clk) begin
        if (rst_n && done3) begin
            if (sb3.size() == 0) unexpected_done("settle3");
            else check_item("settle3", sb3.pop_front(), mask3, ones3, match3);
        end
    end

    // Accept edge counts as edge 1, so done shows after edge 2**N*(SETTLE+1)+1,
    // i.e. 32 cycle-counter ticks after the accept edge for SETTLE=1.
    task automatic apply_stimulus(input logic [15:0] m, input logic [4:0] o, input logic mt);
        exp_t e;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.mask = m; e.ones = o; e.match = mt; e.done_cyc = cyc + 32;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 300 && (sb.size() != 0 || sb0.size() != 0 || sb3.size() != 0
                                || busy || done || busy0 || busy3); i++)
            @(negedge clk);
        check_output({name, "_idle_timeout"}, (i >= 300), 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int errs;
        exp_t e;
        rst_n = 1'b0; start = 1'b0; start_aux = 1'b0; s_sel = 2'd0;
        expected = 16'h0000; expected_aux = 16'h7310;

        // Reset state and idle hold
        #1;
        check_output("reset_async", {x, busy, done, mask, ones, match}, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("reset_idle", {x, busy, done, mask, ones, match}, '0);
        end

        // Default scan against the SoP, with x sequence and busy tracking
        expected = 16'h7310;
        apply_stimulus(16'h7310, 5'd6, 1'b1);
        errs = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (x !== 4'(k / 2) || busy !== 1'b1) errs++;
        end
        check_output("x_seq_busy", errs, 0);
        @(negedge clk);
        check_output("busy_finish", {busy, done}, 2'b01);
        @(negedge clk);
        check_output("x_return", {x, done}, 5'h00);
        repeat (4) @(negedge clk);
        check_output("hold_results", {mask, ones, match}, {16'h7310, 5'd6, 1'b1});
        wait_idle("t2");

        // Wrong reference, all-ones and all-zeros functions
        expected = 16'h7311;
        apply_stimulus(16'h7310, 5'd6, 1'b0);
        wait_idle("t3a");
        s_sel = 2'd1; expected = 16'hFFFF;
        apply_stimulus(16'hFFFF, 5'd16, 1'b1);
        wait_idle("t3b");
        s_sel = 2'd2; expected = 16'h1234;
        apply_stimulus(16'h0000, 5'd0, 1'b1);
        repeat (10) @(negedge clk);
        expected = 16'h0000;
        wait_idle("t3c");

        // start pulses during HOLD and FINISH are ignored
        s_sel = 2'd0; expected = 16'h7310;
        apply_stimulus(16'h7310, 5'd6, 1'b1);
        for (int ed = 2; ed <= 34; ed++) begin
            @(negedge clk);
            start = (ed == 3 || ed == 10 || ed == 32 || ed == 33 || ed == 34);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_output("no_restart_busy", busy, 1'b0);
        wait_idle("t4a");

        // start held high: back-to-back scans with one IDLE cycle between
        start = 1'b1;
        @(posedge clk);
        #1;
        e.mask = 16'h7310; e.ones = 5'd6; e.match = 1'b1; e.done_cyc = cyc + 32;
        sb.push_back(e);
        e.done_cyc = cyc + 66;
        sb.push_back(e);
        repeat (33) @(posedge clk);
        @(negedge clk);
        check_output("b2b_idle_gap", {busy, done}, 2'b00);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("b2b_second_busy", busy, 1'b1);
        wait_idle("t4b");

        // Reset mid-scan clears immediately and never pulses done
        apply_stimulus(16'h7310, 5'd6, 1'b1);
        repeat (11) @(posedge clk);
        #2;
        check_output("pre_reset_nonzero", (mask != 16'h0000), 1'b1);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check_output("reset_midscan", {x, busy, done, mask, ones, match}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("reset_stays_idle", {busy, done}, 2'b00);
        apply_stimulus(16'h7310, 5'd6, 1'b1);
        wait_idle("t5");

        // SETTLE=0 and SETTLE=3 instances
        start_aux = 1'b1;
        @(posedge clk);
        #1;
        start_aux = 1'b0;
        e.mask = 16'h7310; e.ones = 5'd6; e.match = 1'b1;
        e.done_cyc = cyc + 16;
        sb0.push_back(e);
        e.done_cyc = cyc + 64;
        sb3.push_back(e);
        wait_idle("t6");

        check_output("scoreboard_drained", sb.size() + sb0.size() + sb3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
